// File: rtl/lsu_pkg.sv
// Shared definitions for the sub-word load/store sequencer.
// Contents: RV32I width codes, FSM state enumeration, the default address
// limit, and a helper that classifies a request as faulting on width/alignment.
package lsu_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned ADDR_LIMIT_DEFAULT = 112;

    // RV32I funct3 width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } lsu_state_t;

    // 1 when the width code is illegal for the access type or the address is misaligned
    function automatic logic req_fault(input logic       store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic f;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_BU:   f = store;
            F3_H:    f = addr_lo[0];
            F3_HU:   f = store | addr_lo[0];
            F3_W:    f = (addr_lo != 2'b00);
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Combinational lane handling for sub-word accesses.
// Ports:
//   funct3       width code of the captured request
//   addr_lo      captured address bits [1:0] (lane index)
//   rdata        word read from data memory
//   wdata        low 16 bits of the captured store data
//   load_data_c  extracted and sign/zero-extended load result
//   merge_data_c old word with only the addressed byte/halfword lane replaced
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    input  logic [15:0]     wdata,
    output logic [XLEN-1:0] load_data_c,
    output logic [XLEN-1:0] merge_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane extraction
    always_comb begin
        case (addr_lo)
            2'd0:    byte_c = rdata[7:0];
            2'd1:    byte_c = rdata[15:8];
            2'd2:    byte_c = rdata[23:16];
            default: byte_c = rdata[31:24];
        endcase
        half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Load result extension
    always_comb begin
        case (funct3)
            F3_B:    load_data_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   load_data_c = {24'd0, byte_c};
            F3_H:    load_data_c = {{16{half_c[15]}}, half_c};
            F3_HU:   load_data_c = {16'd0, half_c};
            default: load_data_c = rdata;
        endcase
    end

    // Store lane merge; funct3[1:0]==00 is a byte store, otherwise halfword
    always_comb begin
        merge_data_c = rdata;
        if (funct3[1:0] == 2'b00) begin
            case (addr_lo)
                2'd0:    merge_data_c[7:0]   = wdata[7:0];
                2'd1:    merge_data_c[15:8]  = wdata[7:0];
                2'd2:    merge_data_c[23:16] = wdata[7:0];
                default: merge_data_c[31:24] = wdata[7:0];
            endcase
        end else if (addr_lo[1]) begin
            merge_data_c[31:16] = wdata;
        end else begin
            merge_data_c[15:0] = wdata;
        end
    end

endmodule

// File: rtl/lsu_subword_seq.sv
// Load/store sequencer turning RV32I byte/halfword/word accesses into
// word-wide data-memory cycles (read-modify-write for SB/SH).
// Optional feature: define LSU_BOUNDS_CHECK_EN to fault addresses >= ADDR_LIMIT.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   req_*                request handshake, type, width code, address, store data
//   resp_valid/rdata/fault  one-cycle completion with formatted load data
//   mem_*                word-aligned data-memory interface (combinational read data)
module lsu_subword_seq
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_read_en,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_rdata
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    lsu_state_t      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [15:0]     wdata_lo_q, wdata_lo_d;
    logic [XLEN-1:0] merge_q, merge_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            rd_en_q, rd_en_d;
    logic            wr_en_q, wr_en_d;

    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] merge_data_c;
    logic            oob_c;
    logic            fault_c;

    lsu_lane_fmt u_lane_fmt (
        .funct3       (funct3_q),
        .addr_lo      (addr_lo_q),
        .rdata        (mem_rdata),
        .wdata        (wdata_lo_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Request classification at the accept edge
    always_comb begin
        oob_c   = BOUNDS_EN && (req_addr >= XLEN'(ADDR_LIMIT));
        fault_c = req_fault(req_store, req_funct3, req_addr[1:0]) | oob_c;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        wdata_lo_d = wdata_lo_q;
        merge_d    = merge_q;
        mem_addr_d = mem_addr_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    addr_lo_d  = req_addr[1:0];
                    wdata_lo_d = req_wdata[15:0];
                    mem_addr_d = {req_addr[31:2], 2'b00};
                    fault_d    = fault_c;
                    if (fault_c) begin
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (!req_store) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        // full-word store needs no old data
                        merge_d = req_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data_c;
                state_d = RESP;
            end
            RMW_RD: begin
                merge_d = merge_data_c;
                state_d = WRITE;
            end
            WRITE: begin
                rdata_d = '0;
                state_d = RESP;
            end
            RESP: begin
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs registered from the upcoming state so they align with it
        ready_d = (state_d == IDLE);
        valid_d = (state_d == RESP);
        rd_en_d = (state_d == LOAD) || (state_d == RMW_RD);
        wr_en_d = (state_d == WRITE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            wdata_lo_q <= '0;
            merge_q    <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            wdata_lo_q <= wdata_lo_d;
            merge_q    <= merge_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign req_ready    = ready_q;
    assign resp_valid   = valid_q;
    assign resp_rdata   = rdata_q;
    assign resp_fault   = fault_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = merge_q;
    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;

endmodule

// File: tb/tb_lsu_subword_seq.sv
// Directed self-checking bench for lsu_subword_seq with a small word memory.
module tb_lsu_subword_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:31];
    int          rd_cnt   = 0;
    int          wr_cnt   = 0;
    int          both_cnt = 0;
    logic [31:0] last_rd_addr = '0;

    always #5 clk = ~clk;

    lsu_subword_seq dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_rdata    (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[6:2]];

    // Memory shares the system reset: a write seen at a reset edge is dropped
    always @(posedge clk) begin
        if (reset && mem_write_en) begin
            mem[mem_addr[6:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (reset && mem_read_en) begin
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_addr;
        end
        if (mem_read_en && mem_write_en) both_cnt <= both_cnt + 1;
    end

    // Issue one request from IDLE and wait (bounded) for its response
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic flt);
        int n;
        @(negedge clk);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
        if (!resp_valid) lat = 99;
        rd  = resp_rdata;
        flt = resp_fault;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", resp_valid); end
        total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", resp_fault); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", resp_rdata); end
        total++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
            bad++; $display("FAIL rst_strobes got=%b%b exp=00", mem_read_en, mem_write_en); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_merge got=%h exp=0", mem_wdata); end
        reset = 1'b1;
    endtask

    task automatic test_load();
        logic [31:0] a_t [8] = '{32'h0D, 32'h0D, 32'h0E, 32'h0E, 32'h0C, 32'h0C, 32'h0F, 32'h0C};
        logic [2:0]  f_t [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b100, 3'b001};
        logic [31:0] e_t [8] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                 32'h8899AABB, 32'hFFFFFFBB, 32'h00000088, 32'hFFFFAABB};
        int lat; logic [31:0] rd; logic flt; int r0, w0;
        mem[3] = 32'h8899AABB;
        for (int i = 0; i < 8; i++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            do_req(1'b0, f_t[i], a_t[i], 32'h0, lat, rd, flt);
            total++; if (lat != 2) begin bad++; $display("FAIL load%0d_lat got=%0d exp=2", i, lat); end
            total++; if (rd !== e_t[i]) begin bad++; $display("FAIL load%0d_data got=%h exp=%h", i, rd, e_t[i]); end
            total++; if (flt !== 1'b0) begin bad++; $display("FAIL load%0d_fault got=%b exp=0", i, flt); end
            total++; if (rd_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
                bad++; $display("FAIL load%0d_strobes rd=%0d wr=%0d exp rd=1 wr=0", i, rd_cnt - r0, wr_cnt - w0); end
        end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL load_pulse got=%b exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'hFFFFAABB) begin bad++; $display("FAIL load_hold got=%h exp=ffffaabb", resp_rdata); end
    endtask

    task automatic test_store_sub();
        logic [2:0]  f_t [3] = '{3'b000, 3'b001, 3'b000};
        logic [31:0] a_t [3] = '{32'h0A, 32'h08, 32'h0B};
        logic [31:0] d_t [3] = '{32'h000000EE, 32'h1234BEEF, 32'hFFFFFF77};
        logic [31:0] e_t [3] = '{32'h11EE3344, 32'h11EEBEEF, 32'h77EEBEEF};
        int lat; logic [31:0] rd; logic flt; int r0, w0;
        mem[2] = 32'h11223344;
        for (int i = 0; i < 3; i++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            do_req(1'b1, f_t[i], a_t[i], d_t[i], lat, rd, flt);
            total++; if (lat != 3) begin bad++; $display("FAIL sub%0d_lat got=%0d exp=3", i, lat); end
            total++; if (mem[2] !== e_t[i]) begin bad++; $display("FAIL sub%0d_mem got=%h exp=%h", i, mem[2], e_t[i]); end
            total++; if (rd !== 32'h0 || flt !== 1'b0) begin
                bad++; $display("FAIL sub%0d_resp rdata=%h fault=%b exp 0/0", i, rd, flt); end
            total++; if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1) begin
                bad++; $display("FAIL sub%0d_strobes rd=%0d wr=%0d exp rd=1 wr=1", i, rd_cnt - r0, wr_cnt - w0); end
        end
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] rd; logic flt; int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, lat, rd, flt);
        total++; if (lat != 2) begin bad++; $display("FAIL sw_lat got=%0d exp=2", lat); end
        total++; if (mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL sw_mem got=%h exp=cafef00d", mem[4]); end
        total++; if (rd_cnt - r0 != 0 || wr_cnt - w0 != 1) begin
            bad++; $display("FAIL sw_strobes rd=%0d wr=%0d exp rd=0 wr=1", rd_cnt - r0, wr_cnt - w0); end
    endtask

    task automatic test_fault();
        logic        s_t [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f_t [7] = '{3'b001, 3'b010, 3'b001, 3'b011, 3'b100, 3'b111, 3'b101};
        logic [31:0] a_t [7] = '{32'h05, 32'h0E, 32'h03, 32'h00, 32'h00, 32'h04, 32'h02};
        int lat; logic [31:0] rd; logic flt; int r0, w0; logic [31:0] m1;
        m1 = mem[1];
        for (int i = 0; i < 7; i++) begin
            do_req(1'b0, 3'b010, 32'h0C, 32'h0, lat, rd, flt);  // leave non-zero rdata behind
            r0 = rd_cnt; w0 = wr_cnt;
            do_req(s_t[i], f_t[i], a_t[i], 32'hA5A5A5A5, lat, rd, flt);
            total++; if (lat != 1) begin bad++; $display("FAIL flt%0d_lat got=%0d exp=1", i, lat); end
            total++; if (flt !== 1'b1) begin bad++; $display("FAIL flt%0d_fault got=%b exp=1", i, flt); end
            total++; if (rd !== 32'h0) begin bad++; $display("FAIL flt%0d_rdata got=%h exp=0", i, rd); end
            total++; if (rd_cnt - r0 != 0 || wr_cnt - w0 != 0) begin
                bad++; $display("FAIL flt%0d_strobes rd=%0d wr=%0d exp 0/0", i, rd_cnt - r0, wr_cnt - w0); end
        end
        total++; if (mem[1] !== m1) begin bad++; $display("FAIL flt_mem got=%h exp=%h", mem[1], m1); end
    endtask

    task automatic test_bounds();
        int lat; logic [31:0] rd; logic flt; int r0;
        mem[27] = 32'h0F0E0D0C;
        mem[28] = 32'h5A5A1234;
        do_req(1'b0, 3'b010, 32'h6C, 32'h0, lat, rd, flt);
        total++; if (lat != 2 || flt !== 1'b0 || rd !== 32'h0F0E0D0C) begin
            bad++; $display("FAIL bnd_inrange lat=%0d fault=%b rdata=%h exp 2/0/0f0e0d0c", lat, flt, rd); end
        r0 = rd_cnt;
        do_req(1'b0, 3'b010, 32'h70, 32'h0, lat, rd, flt);
`ifdef LSU_BOUNDS_CHECK_EN
        total++; if (lat != 1 || flt !== 1'b1) begin
            bad++; $display("FAIL bnd_oob lat=%0d fault=%b exp 1/1", lat, flt); end
        total++; if (rd_cnt - r0 != 0) begin bad++; $display("FAIL bnd_oob_strobe rd=%0d exp=0", rd_cnt - r0); end
`else
        total++; if (lat != 2 || flt !== 1'b0 || rd !== 32'h5A5A1234) begin
            bad++; $display("FAIL bnd_pass lat=%0d fault=%b rdata=%h exp 2/0/5a5a1234", lat, flt, rd); end
        total++; if (rd_cnt - r0 != 1 || last_rd_addr !== 32'h70) begin
            bad++; $display("FAIL bnd_pass_addr rd=%0d addr=%h exp 1/70", rd_cnt - r0, last_rd_addr); end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);  // c0: IDLE, SW presented
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h18; req_wdata = 32'h0BADC0DE; req_valid = 1'b1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_c0_ready got=%b exp=1", req_ready); end
        @(negedge clk);  // c1: WRITE, LW now presented and held
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h18; req_wdata = 32'h0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_c1_ready got=%b exp=0", req_ready); end
        @(negedge clk);  // c2: RESP of the SW
        total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_c2 valid=%b ready=%b exp 1/0", resp_valid, req_ready); end
        @(negedge clk);  // c3: IDLE, LW accepted at the next edge
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_c3 valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
        @(negedge clk);  // c4: LOAD
        req_valid = 1'b0;
        total++; if (mem_read_en !== 1'b1 || mem_addr !== 32'h18 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_c4 rd_en=%b addr=%h valid=%b exp 1/18/0", mem_read_en, mem_addr, resp_valid); end
        @(negedge clk);  // c5: RESP of the LW
        total++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADC0DE) begin
            bad++; $display("FAIL b2b_c5 valid=%b rdata=%h exp 1/0badc0de", resp_valid, resp_rdata); end
    endtask

    task automatic test_reset_mid_write();
        int w0; int vcnt;
        mem[5] = 32'h01020304;
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b001; req_addr = 32'h16; req_wdata = 32'h0000AAAA; req_valid = 1'b1;
        @(negedge clk);  // RMW_RD
        req_valid = 1'b0;
        total++; if (mem_read_en !== 1'b1) begin bad++; $display("FAIL rmw_rd_en got=%b exp=1", mem_read_en); end
        @(negedge clk);  // WRITE
        total++; if (mem_write_en !== 1'b1) begin bad++; $display("FAIL rmw_wr_en got=%b exp=1", mem_write_en); end
        w0 = wr_cnt;
        reset = 1'b0;
        @(negedge clk);
        total++; if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0) begin
            bad++; $display("FAIL abort_strobes got=%b%b exp=00", mem_read_en, mem_write_en); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        reset = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid === 1'b1 || mem_write_en === 1'b1) vcnt++;
            @(negedge clk);
        end
        total++; if (vcnt != 0) begin bad++; $display("FAIL abort_no_resp cycles_active=%0d exp=0", vcnt); end
        total++; if (mem[5] !== 32'h01020304 || wr_cnt != w0) begin
            bad++; $display("FAIL abort_mem got=%h writes=%0d exp=01020304/0", mem[5], wr_cnt - w0); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        test_reset();
        test_load();
        test_store_sub();
        test_store_word();
        test_fault();
        test_bounds();
        test_back_to_back();
        test_reset_mid_write();
        total++; if (both_cnt != 0) begin bad++; $display("FAIL strobe_overlap cycles=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
